stdout_line_arbiter: RTL and testbench
======================================

# stdout_line_arbiter

Shares one physical stdout byte sink between the cores of a cluster. It presents a per-core peripheral-style slave port at the stdout device, accumulates each core's characters into a private line buffer, and releases complete lines atomically. A round-robin scheduler drains the lines onto a single byte stream. Lines from different cores are therefore never interleaved. The block sits between the per-core peripheral demux and the cluster's real stdout/UART device.

## Interface
- `NumCores`, 8: number of requester ports (≥2).
- `LineDepth`, 32: bytes per core line buffer (power of two, ≥2).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_i` in NumCores: per-core access request.
- `wen_i` in NumCores: 1 = read, 0 = write (PULP convention).
- `wdata_i` in NumCores×32: write data; only bits [7:0] are used.
- `gnt_o` out NumCores: access accepted this cycle.
- `r_valid_o` out NumCores: response, one cycle after `gnt_o`.
- `r_rdata_o` out NumCores×32: response data, always 0.
- `out_valid_o` out 1: output byte valid.
- `out_data_o` out 8: output byte.
- `out_core_o` out $clog2(NumCores): source core of the byte.
- `out_last_o` out 1: last byte of the line.
- `out_ready_i` in 1: sink accepts the byte.

## Operation
- Per-core state is FILL or PENDING, with a count in 0..LineDepth.
- **Write in FILL:** `gnt_o` is combinational (req & ~wen & FILL).
  - byte 0x0A with count > 0 → PENDING; the newline is not stored.
  - byte 0x0A with count = 0 → dropped; stays in FILL.
  - any other byte is stored at index count and count increments; reaching LineDepth → PENDING (forced flush).
- **Write in PENDING:** `gnt_o` = 0; the core stalls until its line has drained.
- **Read:** granted in any state with no buffer effect; `r_rdata_o` = 0.
- **Response:** `r_valid_o[i]` = 1 exactly one cycle after every grant, for both reads and writes.
- **Scheduler states:**
  - IDLE: if any core is PENDING, select the first PENDING core strictly after `rr_ptr` (cyclic), set rd = 0, go to SEND.
  - SEND: drive `out_valid_o` = 1, `out_data_o` = buf[sel][rd], `out_core_o` = sel, `out_last_o` = (rd == count−1).
    - On handshake with not-last: rd++.
    - On handshake with last: count[sel] = 0, core sel → FILL, `rr_ptr` = sel, go to IDLE.
- **Output hold:** while `out_valid_o` is high and `out_ready_i` is low, all out_* outputs stay stable.
- **Reset:** clears all buffers, counts, states and `rr_ptr` (= NumCores−1, so core 0 has first priority) and the scheduler (IDLE); partial lines are discarded.

## Timing
- Reset values: `gnt_o` = 0 (no req), `r_valid_o` = 0, `r_rdata_o` = 0, `out_valid_o` = 0, `out_data_o` = 0, `out_core_o` = 0, `out_last_o` = 0.
- Line-complete write granted at cycle t:
  - PENDING at t+1;
  - scheduler selects at t+1;
  - first byte valid at t+2.
- Throughput is 1 byte/cycle within a line, with exactly one IDLE cycle between lines.
- The core being drained returns to FILL in the cycle after its last handshake, so its next write can be granted then.
- Simultaneous PENDING cores are served in round-robin order; no core waits for more than NumCores−1 other lines.
- Cores in FILL are never blocked by the scheduler.
- An asserted reset during SEND drops `out_valid_o` immediately (asynchronous).

## Structure
- `stdout_arb_pkg` contains:
  - `core_state_e` {FILL, PENDING};
  - `sched_state_e` {IDLE, SEND};
  - `localparam NEWLINE = 8'h0A`;
  - the count/pointer width helpers.
- Sub-module `stdout_line_buf` holds one core's storage, count, FILL/PENDING state, grant and response logic; it is instantiated NumCores times.
- The top level holds the round-robin scheduler and the output mux.

## Test plan
- **Reset:** assert `rst_i` → all outputs 0; after release, core 0 writes 'A' → `gnt_o[0]` in the same cycle, `r_valid_o[0]` the next cycle.
- **Basic line:** core 0 writes 'H','i',0x0A back-to-back → 3 grants; two cycles after the newline grant, the stream carries 'H'(core 0, last 0) then 'i'(core 0, last 1) with `out_ready_i` = 1.
- **Forced flush:** LineDepth = 4, core 1 writes "ABCDE\n" → 'E' stalled (gnt 0) until the cycle after the 'D' handshake; stream "ABCD" with last on 'D', then "E" with last.
- **Round-robin:** cores 2 and 5 complete lines in the same cycle with `rr_ptr` = 0 → core 2's line fully precedes core 5's; a repeat contest with `rr_ptr` = 2 again picks 5 before 2 (5 is first after 2).
- **Backpressure:** hold `out_ready_i` = 0 for 5 cycles mid-line → out_* outputs stable, no byte lost or duplicated.
- **Reads, empty newline, reset mid-SEND:**
  - a read → gnt, `r_valid_o`, data 0, buffer unchanged;
  - a lone 0x0A → no output;
  - reset mid-SEND → `out_valid_o` = 0 at once and the line is discarded.

Source files
------------

// File: rtl/stdout_arb_pkg.sv
// Shared types and width helpers for the cluster stdout line arbiter.
// Per-core FILL/PENDING state, scheduler state and sizing functions.
package stdout_arb_pkg;

  typedef enum logic {
    FILL,
    PENDING
  } core_state_e;

  typedef enum logic {
    IDLE,
    SEND
  } sched_state_e;

  localparam logic [7:0] NEWLINE = 8'h0A;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stdout_line_buf.sv
// One core's line buffer: storage, fill count, FILL/PENDING state,
// peripheral-style grant and one-cycle response.
module stdout_line_buf
  import stdout_arb_pkg::*;
#(
  parameter int LineDepth = 32,
  localparam int IW = idx_w(LineDepth),
  localparam int CW = cnt_w(LineDepth)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          wen_i,
  input  logic [31:0]   wdata_i,
  output logic          gnt_o,
  output logic          r_valid_o,
  output logic [31:0]   r_rdata_o,
  input  logic [IW-1:0] rd_idx_i,
  input  logic          clear_i,
  output logic          pending_o,
  output logic [CW-1:0] count_o,
  output logic [7:0]    rd_data_o
);

  core_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LineDepth-1:0][7:0] mem_q;
  logic [7:0] wbyte;
  logic wr, we;
  logic unused_wdata;

  assign wbyte = wdata_i[7:0];
  assign unused_wdata = ^wdata_i[31:8];

  assign wr    = req_i & ~wen_i & (state_q == FILL);
  assign gnt_o = req_i & (wen_i | (state_q == FILL));

  assign r_rdata_o = '0;
  assign pending_o = (state_q == PENDING);
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q[rd_idx_i];

  // The newline itself is never stored; an empty line is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    if (clear_i) begin
      state_d = FILL;
      cnt_d   = '0;
    end else if (wr) begin
      if (wbyte == NEWLINE) begin
        if (cnt_q != '0) state_d = PENDING;
      end else begin
        we    = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CW'(LineDepth)) state_d = PENDING;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      r_valid_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_valid_o <= gnt_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q[cnt_q[IW-1:0]] <= wbyte;
    end
  end

endmodule

// File: rtl/stdout_line_arbiter.sv
// Cluster stdout sharing: per-core line buffers drained whole-line
// by a round-robin scheduler onto one byte stream.
module stdout_line_arbiter
  import stdout_arb_pkg::*;
#(
  parameter int NumCores  = 8,
  parameter int LineDepth = 32,
  localparam int PW = idx_w(NumCores),
  localparam int IW = idx_w(LineDepth),
  localparam int CW = cnt_w(LineDepth)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumCores-1:0]       req_i,
  input  logic [NumCores-1:0]       wen_i,
  input  logic [NumCores-1:0][31:0] wdata_i,
  output logic [NumCores-1:0]       gnt_o,
  output logic [NumCores-1:0]       r_valid_o,
  output logic [NumCores-1:0][31:0] r_rdata_o,
  output logic                      out_valid_o,
  output logic [7:0]                out_data_o,
  output logic [PW-1:0]             out_core_o,
  output logic                      out_last_o,
  input  logic                      out_ready_i
);

  sched_state_e state_q, state_d;
  logic [PW-1:0] sel_q, sel_d, rr_q, rr_d, pick;
  logic [IW-1:0] rd_q, rd_d;
  logic [NumCores-1:0] pending, clear;
  logic [NumCores-1:0][CW-1:0] count;
  logic [NumCores-1:0][7:0] rd_data;
  logic found, is_last;
  int idx;

  for (genvar g = 0; g < NumCores; g++) begin : g_buf
    stdout_line_buf #(.LineDepth(LineDepth)) u_buf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_i[g]),
      .wen_i     (wen_i[g]),
      .wdata_i   (wdata_i[g]),
      .gnt_o     (gnt_o[g]),
      .r_valid_o (r_valid_o[g]),
      .r_rdata_o (r_rdata_o[g]),
      .rd_idx_i  (rd_q),
      .clear_i   (clear[g]),
      .pending_o (pending[g]),
      .count_o   (count[g]),
      .rd_data_o (rd_data[g])
    );
  end

  // First pending core strictly after rr_q, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NumCores; k++) begin
      idx = (int'(rr_q) + k) % NumCores;
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  assign is_last = (CW'(rd_q) + 1'b1) == count[sel_q];

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rd_d        = rd_q;
    rr_d        = rr_q;
    clear       = '0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_core_o  = '0;
    out_last_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          rd_d    = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid_o = 1'b1;
        out_data_o  = rd_data[sel_q];
        out_core_o  = sel_q;
        out_last_o  = is_last;
        if (out_ready_i) begin
          if (is_last) begin
            clear[sel_q] = 1'b1;
            rr_d         = sel_q;
            state_d      = IDLE;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rd_q    <= '0;
      rr_q    <= PW'(NumCores - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_stdout_line_arbiter.sv
// Bench for stdout_line_arbiter: queue-based line model checked every
// cycle, directed scenarios pinned with literal expectations, random soak.
module tb_stdout_line_arbiter;

  localparam int NC = 8;
  localparam int LD = 4;

  logic clk, rst;
  logic [NC-1:0] req, wen, gnt, rv;
  logic [NC-1:0][31:0] wdata, rdata;
  logic out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic [2:0] out_core;

  stdout_line_arbiter #(.NumCores(NC), .LineDepth(LD)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .wen_i       (wen),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .r_valid_o   (rv),
    .r_rdata_o   (rdata),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_core_o  (out_core),
    .out_last_o  (out_last),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int c;
    logic l;
  } ev_t;

  ev_t log_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Model: a byte queue per core, a pending flag, and the line in flight.
  logic [7:0] ml[NC][$];
  bit mpend[NC];
  bit mrv[NC];
  int mrr;
  bit msend;
  int mcur;
  logic [7:0] mstr[$];
  logic [NC-1:0] eg, erv;
  ev_t ev;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  task automatic m_reset();
    for (int c = 0; c < NC; c++) begin
      ml[c].delete();
      mpend[c] = 0;
      mrv[c] = 0;
    end
    mrr = NC - 1;
    msend = 0;
    mcur = 0;
    mstr.delete();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_r_valid", 32'(rv), 0);
      chk("rst_out_bits", {out_data, out_core, out_last}, 0);
      m_reset();
    end else begin
      for (int c = 0; c < NC; c++) begin
        eg[c] = req[c] & (wen[c] | !mpend[c]);
        erv[c] = mrv[c];
      end
      chk("gnt", 32'(gnt), 32'(eg));
      chk("r_valid", 32'(rv), 32'(erv));
      chk("r_rdata", 32'(|rdata), 0);
      chk("out_valid", 32'(out_valid), 32'(msend));
      if (msend) begin
        chk("out_data", 32'(out_data), 32'(mstr[0]));
        chk("out_core", 32'(out_core), mcur);
        chk("out_last", 32'(out_last), 32'(mstr.size() == 1));
        if (out_ready) begin
          ev.d = mstr[0];
          ev.c = mcur;
          ev.l = (mstr.size() == 1);
          log_q.push_back(ev);
          void'(mstr.pop_front());
          if (mstr.size() == 0) begin
            msend = 0;
            mrr = mcur;
            ml[mcur].delete();
            mpend[mcur] = 0;
          end
        end
      end else begin
        chk("idle_out_bits", {out_data, out_core, out_last}, 0);
        for (int k = 1; k <= NC; k++) begin
          if (!msend && mpend[(mrr + k) % NC]) begin
            mcur = (mrr + k) % NC;
            msend = 1;
            mstr = ml[mcur];
          end
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (eg[c] && !wen[c]) begin
          if (wdata[c][7:0] == 8'h0A) begin
            if (ml[c].size() > 0) mpend[c] = 1;
          end else begin
            ml[c].push_back(wdata[c][7:0]);
            if (ml[c].size() == LD) mpend[c] = 1;
          end
        end
        mrv[c] = eg[c];
      end
    end
  end

  task automatic wait_gnt(input int c);
    int n = 0;
    forever begin
      @(negedge clk);
      if (gnt[c]) break;
      n++;
      if (n > 200) begin
        timeout("wait_gnt");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int c, input string s);
    for (int i = 0; i < s.len(); i++) begin
      req[c] = 1'b1;
      wen[c] = 1'b0;
      wdata[c] = {24'd0, s[i]};
      wait_gnt(c);
    end
    req[c] = 1'b0;
    wdata[c] = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    bit busy;
    forever begin
      @(negedge clk);
      #1;
      busy = msend;
      for (int c = 0; c < NC; c++) busy |= mpend[c];
      if (!busy) break;
      n++;
      if (n > 500) begin
        timeout("wait_drain");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int sz);
    int n = 0;
    while (log_q.size() < sz) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 200) begin
        timeout("wait_log");
        break;
      end
    end
  endtask

  task automatic chk_log(input string name, input int i, input logic [7:0] d,
                         input int c, input logic l);
    if (i >= log_q.size()) begin
      timeout({name, "_missing"});
    end else begin
      chk({name, "_data"}, 32'(log_q[i].d), 32'(d));
      chk({name, "_core"}, log_q[i].c, c);
      chk({name, "_last"}, 32'(log_q[i].l), 32'(l));
    end
  endtask

  int n;
  string s5;

  initial begin
    rst = 1'b1;
    req = '0;
    wen = '0;
    wdata = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_valid", 32'(out_valid), 0);
    rst = 1'b0;

    // Same-cycle grant, response the cycle after.
    req[0] = 1'b1;
    wdata[0] = 32'h41;
    @(negedge clk);
    chk("first_gnt0", 32'(gnt[0]), 1);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("first_rvalid0", 32'(rv[0]), 1);
    @(posedge clk);
    #1;
    send_line(0, "\n");
    wait_drain();
    chk("a_count", log_q.size(), 1);
    chk_log("a_line", 0, 8'h41, 0, 1);

    log_q.delete();
    send_line(0, "Hi\n");
    wait_drain();
    chk("hi_count", log_q.size(), 2);
    chk_log("hi0", 0, 8'h48, 0, 0);
    chk_log("hi1", 1, 8'h69, 0, 1);

    log_q.delete();
    s5 = "ABCDE";
    send_line(1, "ABCDE\n");
    wait_drain();
    chk("flush_count", log_q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk_log("flush", i, s5[i], 1, (i >= 3));

    send_line(0, "z\n");
    wait_drain();
    log_q.delete();
    fork
      send_line(2, "P\n");
      send_line(5, "Q\n");
    join
    wait_drain();
    chk_log("rr_a0", 0, 8'h50, 2, 1);
    chk_log("rr_a1", 1, 8'h51, 5, 1);
    send_line(2, "r\n");
    wait_drain();
    log_q.delete();
    fork
      send_line(2, "S\n");
      send_line(5, "T\n");
    join
    wait_drain();
    chk_log("rr_b0", 0, 8'h54, 5, 1);
    chk_log("rr_b1", 1, 8'h53, 2, 1);

    log_q.delete();
    send_line(3, "WXY\n");
    wait_log(1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(out_data), 32'h58);
      chk("bp_hold_valid", 32'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    chk("bp_count", log_q.size(), 3);
    chk_log("bp0", 0, 8'h57, 3, 0);
    chk_log("bp1", 1, 8'h58, 3, 0);
    chk_log("bp2", 2, 8'h59, 3, 1);

    log_q.delete();
    send_line(4, "M");
    req[4] = 1'b1;
    wen[4] = 1'b1;
    @(negedge clk);
    chk("read_gnt", 32'(gnt[4]), 1);
    @(posedge clk);
    #1;
    req[4] = 1'b0;
    wen[4] = 1'b0;
    @(negedge clk);
    chk("read_rvalid", 32'(rv[4]), 1);
    chk("read_rdata", rdata[4], 0);
    @(posedge clk);
    #1;
    send_line(4, "\n");
    wait_drain();
    chk("read_count", log_q.size(), 1);
    chk_log("read_line", 0, 8'h4D, 4, 1);

    log_q.delete();
    send_line(6, "\n");
    repeat (10) @(posedge clk);
    #1;
    chk("lone_nl_count", log_q.size(), 0);

    log_q.delete();
    send_line(7, "RST\n");
    wait_log(1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_discard", log_q.size(), 1);

    repeat (3000) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++) begin
        req[c] = ($urandom_range(2) == 0);
        wen[c] = ($urandom_range(4) == 0);
        wdata[c] = ($urandom_range(3) == 0) ? 32'h0A
                 : 32'(8'h61 + $urandom_range(25));
      end
      out_ready = ($urandom_range(3) != 0);
    end
    @(posedge clk);
    #1;
    req = '0;
    out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
